// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: instruction decode, ALU op codes and
// sequencer state encoding.
package k_and_s_pkg;

  localparam int unsigned INSTR_W = 5;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [INSTR_W-1:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD   = 3'd3,
    S_STORE  = 3'd4,
    S_ALU    = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } cu_state_t;

  // Execute state an instruction is dispatched to from decode.
  function automatic cu_state_t dispatch_state(input decoded_instruction_type instr);
    case (instr)
      I_LOAD:                                   return S_LOAD;
      I_STORE:                                  return S_STORE;
      I_MOVE, I_ADD, I_SUB, I_AND, I_OR:        return S_ALU;
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
      I_BNNEG, I_BOV, I_BNOV:                   return S_BRANCH;
      I_HALT:                                   return S_HALT;
      default:                                  return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch condition evaluation from the decoded instruction and registered flags.
import k_and_s_pkg::*;

module cu_branch_cond (
  input  decoded_instruction_type instr,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    taken
);

  // No branch in this ISA tests the carry flag; kept on the port for reuse.
  logic unused_carry;
  assign unused_carry = unsigned_overflow;

  always_comb begin
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = signed_overflow;
      I_BNOV:   taken = !signed_overflow;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the K&S datapath: fetch / decode / execute.
// Optional retired-instruction counter enabled by CU_INSTR_COUNT_EN.
import k_and_s_pkg::*;

module control_unit (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [OP_W-1:0]         operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  cu_state_t state, next_state;
  logic      taken;

  logic            branch_d, pc_enable_d, ir_enable_d, addr_sel_d, c_sel_d;
  logic [OP_W-1:0] operation_d;
  logic            write_reg_enable_d, flags_reg_enable_d, ram_write_enable_d, halt_d;

  cu_branch_cond u_branch_cond (
    .instr             (decoded_instruction),
    .zero_op           (zero_op),
    .neg_op            (neg_op),
    .unsigned_overflow (unsigned_overflow),
    .signed_overflow   (signed_overflow),
    .taken             (taken)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = dispatch_state(decoded_instruction);
      S_LOAD,
      S_STORE,
      S_ALU,
      S_BRANCH: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so the registered strobes line
  // up with the state they belong to. Instruction and flags are stable from
  // the end of fetch onward, so sampling them a cycle early is safe.
  always_comb begin
    branch_d           = 1'b0;
    pc_enable_d        = 1'b0;
    ir_enable_d        = 1'b0;
    addr_sel_d         = 1'b0;
    c_sel_d            = 1'b0;
    operation_d        = ALU_ADD;
    write_reg_enable_d = 1'b0;
    flags_reg_enable_d = 1'b0;
    ram_write_enable_d = 1'b0;
    halt_d             = 1'b0;
    case (next_state)
      S_FETCH:  ir_enable_d = 1'b1;
      S_DECODE: pc_enable_d = 1'b1;
      S_LOAD: begin
        addr_sel_d         = 1'b1;
        c_sel_d            = 1'b1;
        write_reg_enable_d = 1'b1;
      end
      S_STORE: begin
        addr_sel_d         = 1'b1;
        ram_write_enable_d = 1'b1;
      end
      S_ALU: begin
        write_reg_enable_d = 1'b1;
        flags_reg_enable_d = 1'b1;
        case (decoded_instruction)
          I_SUB:   operation_d = ALU_SUB;
          I_AND:   operation_d = ALU_AND;
          I_OR:    operation_d = ALU_OR;
          I_MOVE: begin
            operation_d        = ALU_OR;
            flags_reg_enable_d = 1'b0;
          end
          default: operation_d = ALU_ADD;
        endcase
      end
      S_BRANCH: begin
        branch_d    = taken;
        pc_enable_d = taken;
      end
      S_HALT:   halt_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; async reset clears every strobe mid-instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch           <= 1'b0;
      pc_enable        <= 1'b0;
      ir_enable        <= 1'b0;
      addr_sel         <= 1'b0;
      c_sel            <= 1'b0;
      operation        <= ALU_ADD;
      write_reg_enable <= 1'b0;
      flags_reg_enable <= 1'b0;
      ram_write_enable <= 1'b0;
      halt             <= 1'b0;
    end else begin
      branch           <= branch_d;
      pc_enable        <= pc_enable_d;
      ir_enable        <= ir_enable_d;
      addr_sel         <= addr_sel_d;
      c_sel            <= c_sel_d;
      operation        <= operation_d;
      write_reg_enable <= write_reg_enable_d;
      flags_reg_enable <= flags_reg_enable_d;
      ram_write_enable <= ram_write_enable_d;
      halt             <= halt_d;
    end
  end

`ifdef CU_INSTR_COUNT_EN
  logic retire_c;

  // An instruction retires when it returns to fetch or first enters halt.
  always_comb begin
    retire_c = 1'b0;
    if (next_state == S_FETCH && state != S_IDLE && state != S_FETCH)
      retire_c = 1'b1;
    if (next_state == S_HALT && state != S_HALT)
      retire_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_count <= '0;
    else if (retire_c && instr_count != {CNT_W{1'b1}})
      instr_count <= instr_count + CNT_W'(1);
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; expected strobe patterns are hand-derived.
// Counter checks follow CU_INSTR_COUNT_EN.
`timescale 1ns/1ps
import k_and_s_pkg::*;

module tb_control_unit;

  logic clk = 1'b0;
  logic rst;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [15:0] instr_count;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;

  // Packed view of all strobes: bit positions below.
  localparam logic [15:0] BR   = 16'h0001;
  localparam logic [15:0] PC   = 16'h0002;
  localparam logic [15:0] IR   = 16'h0004;
  localparam logic [15:0] ADDR = 16'h0008;
  localparam logic [15:0] CSEL = 16'h0010;
  localparam logic [15:0] OP_SUB = 16'h0020;
  localparam logic [15:0] OP_AND = 16'h0040;
  localparam logic [15:0] OP_OR  = 16'h0060;
  localparam logic [15:0] WRE  = 16'h0080;
  localparam logic [15:0] FRE  = 16'h0100;
  localparam logic [15:0] RAM  = 16'h0200;
  localparam logic [15:0] HALT = 16'h0400;

  logic [15:0] obs;
  assign obs = {5'b0, halt, ram_write_enable, flags_reg_enable, write_reg_enable,
                operation, c_sel, addr_sel, ir_enable, pc_enable, branch};

  control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .instr_count         (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag);
`ifdef CU_INSTR_COUNT_EN
    check(tag, instr_count, 16'(exp_cnt));
`else
    check(tag, instr_count, 16'h0000);
`endif
  endtask

  // Entry: state is FETCH, sampled 1 ns after the edge. Exit: state is FETCH again.
  task automatic run_instr(input string tag, input decoded_instruction_type instr,
                           input logic z, input logic n, input logic v, input logic c,
                           input int lat, input logic [15:0] exp_exec);
    decoded_instruction = instr;
    zero_op = z; neg_op = n; signed_overflow = v; unsigned_overflow = c;
    check({tag, "_fetch"}, obs, IR);
    step();
    check({tag, "_decode"}, obs, PC);
    step();
    check({tag, "_exec"}, obs, exp_exec);
    if (lat == 3) step();
    exp_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    decoded_instruction = I_NOP;
    zero_op = 1'b0; neg_op = 1'b0; unsigned_overflow = 1'b0; signed_overflow = 1'b0;
    #22;
    rst = 1'b0;
    check("idle", obs, 16'h0000);
    check_count("count_reset");
    step();

    for (int i = 0; i < 5; i++) run_instr("nop", I_NOP, 0, 0, 0, 0, 2, IR);
    check_count("count_5nop");

    run_instr("unlisted", decoded_instruction_type'(5'h1F), 0, 0, 0, 0, 2, IR);
    run_instr("add",  I_ADD,  0, 0, 0, 0, 3, WRE | FRE);
    run_instr("sub",  I_SUB,  0, 0, 0, 0, 3, WRE | FRE | OP_SUB);
    run_instr("and",  I_AND,  0, 0, 0, 0, 3, WRE | FRE | OP_AND);
    run_instr("or",   I_OR,   0, 0, 0, 0, 3, WRE | FRE | OP_OR);
    run_instr("move", I_MOVE, 0, 0, 0, 0, 3, WRE | OP_OR);
    run_instr("store", I_STORE, 0, 0, 0, 0, 3, ADDR | RAM);
    run_instr("load",  I_LOAD,  0, 0, 0, 0, 3, ADDR | CSEL | WRE);

    run_instr("bzero_t",  I_BZERO,  1, 0, 0, 0, 3, BR | PC);
    run_instr("bzero_n",  I_BZERO,  0, 1, 1, 1, 3, 16'h0000);
    run_instr("bnzero_t", I_BNZERO, 0, 0, 0, 0, 3, BR | PC);
    run_instr("bnzero_n", I_BNZERO, 1, 0, 0, 0, 3, 16'h0000);
    run_instr("bneg_t",   I_BNEG,   0, 1, 0, 0, 3, BR | PC);
    run_instr("bneg_n",   I_BNEG,   1, 0, 1, 1, 3, 16'h0000);
    run_instr("bnneg_t",  I_BNNEG,  0, 0, 0, 0, 3, BR | PC);
    run_instr("bnneg_n",  I_BNNEG,  0, 1, 0, 0, 3, 16'h0000);
    run_instr("bov_t",    I_BOV,    0, 0, 1, 0, 3, BR | PC);
    run_instr("bov_n",    I_BOV,    0, 0, 0, 1, 3, 16'h0000);
    run_instr("bnov_t",   I_BNOV,   0, 0, 0, 1, 3, BR | PC);
    run_instr("bnov_n",   I_BNOV,   0, 0, 1, 0, 3, 16'h0000);
    run_instr("branch",   I_BRANCH, 0, 0, 0, 0, 3, BR | PC);
    check_count("count_mix");

    // Reset in the middle of a store: strobe must drop without a clock edge.
    decoded_instruction = I_STORE;
    check("st_fetch", obs, IR);
    step();
    step();
    check("st_exec", obs, ADDR | RAM);
    #2 rst = 1'b1;
    #1;
    check("st_rst_async", obs, 16'h0000);
    exp_cnt = 0;
    check_count("count_rst");
    #3 rst = 1'b0;
    check("st_rst_idle", obs, 16'h0000);
    step();

    decoded_instruction = I_HALT;
    check("halt_fetch", obs, IR);
    step();
    check("halt_decode", obs, PC);
    step();
    exp_cnt++;
    check("halt_enter", obs, HALT);
    check_count("count_halt");
    decoded_instruction = I_NOP;
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_hold", obs, HALT);
    end
    check_count("count_halt_hold");
    #2 rst = 1'b1;
    #1;
    check("halt_rst", obs, 16'h0000);
    #3 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencer for the K&S processor datapath. Drives every datapath control strobe (PC, IR, register file, flags, address mux, ALU operation) and the RAM write strobe. It steps each instruction through fetch, decode and execute from the decoded instruction and the registered flags. It sits beside `data_path` in the processor top level and is the only source of the datapath's control inputs.

## Interface
Parameters:
- none; widths and encodings come from `k_and_s_pkg`.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `decoded_instruction`  in  `decoded_instruction_type`  from datapath decode
- `zero_op`  in  1  registered zero flag
- `neg_op`  in  1  registered negative flag
- `unsigned_overflow`  in  1  registered carry flag
- `signed_overflow`  in  1  registered overflow flag
- `branch`  out  1  PC source: 1 = instruction address, 0 = PC+1
- `pc_enable`  out  1  PC load
- `ir_enable`  out  1  IR load
- `addr_sel`  out  1  RAM address: 0 = PC, 1 = instruction address
- `c_sel`  out  1  register write data: 0 = ALU, 1 = `data_in`
- `operation`  out  2  ALU op: `ALU_ADD`=00, `ALU_SUB`=01, `ALU_AND`=10, `ALU_OR`=11
- `write_reg_enable`  out  1  register file write
- `flags_reg_enable`  out  1  flags register load
- `ram_write_enable`  out  1  RAM write strobe
- `halt`  out  1  processor stopped
- `instr_count`  out  16  retired instruction count (see Configuration)

## Operation
- States: `S_IDLE`, `S_FETCH`, `S_DECODE`, `S_LOAD`, `S_STORE`, `S_ALU`, `S_BRANCH`, `S_HALT`.
- Outputs decode from state and, in execute states only, from `decoded_instruction`/flags. Every output not listed for a state is 0.
- `S_IDLE`: all outputs 0. Next state is `S_FETCH`.
- `S_FETCH`: `addr_sel`=0, `ir_enable`=1. Next state is `S_DECODE`.
- `S_DECODE`: `pc_enable`=1, `branch`=0 (PC+1). Next state by instruction:
  - `I_NOP` → `S_FETCH`
  - `I_LOAD` → `S_LOAD`
  - `I_STORE` → `S_STORE`
  - `I_MOVE`/`I_ADD`/`I_SUB`/`I_AND`/`I_OR` → `S_ALU`
  - any branch → `S_BRANCH`
  - `I_HALT` → `S_HALT`
  - any unlisted encoding is treated as `I_NOP`.
- `S_LOAD`: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1. Next state is `S_FETCH`.
- `S_STORE`: `addr_sel`=1, `ram_write_enable`=1. Next state is `S_FETCH`.
- `S_ALU`: `c_sel`=0, `write_reg_enable`=1, `operation` per instruction.
  - `I_MOVE` uses `ALU_OR` with `flags_reg_enable`=0.
  - All other ALU instructions set `flags_reg_enable`=1.
  - Next state is `S_FETCH`.
- `S_BRANCH`: taken ⇒ `branch`=1, `pc_enable`=1; not taken ⇒ no strobes. Next state is `S_FETCH`. Branch conditions:
  - `I_BRANCH`: always taken
  - `I_BZERO`: `zero_op`
  - `I_BNZERO`: !`zero_op`
  - `I_BNEG`: `neg_op`
  - `I_BNNEG`: !`neg_op`
  - `I_BOV`: `signed_overflow`
  - `I_BNOV`: !`signed_overflow`
- `S_HALT`: `halt`=1, all strobes 0. The block stays in `S_HALT` until `rst`.

## Timing
- Reset: state = `S_IDLE`, all outputs 0, `instr_count`=0. Reset takes effect immediately and asynchronously, including mid-instruction. A `S_STORE` interrupted by reset drops `ram_write_enable` the same cycle.
- First `S_FETCH` occurs 1 cycle after reset release.
- Instruction latency in cycles: NOP 2, LOAD 3, STORE 3, ALU/MOVE 3, branch 3 (taken or not). HALT reaches `S_HALT` in 3.
- Branches test flags registered by a preceding ALU instruction. Flags written in `S_ALU` are visible in the next instruction's `S_BRANCH` with no stall.
- Each strobe is asserted for exactly one cycle per instruction; none stays high across two consecutive states.

## Configuration
- `CU_INSTR_COUNT_EN` defined:
  - `instr_count` increments by 1 on the cycle an instruction leaves its final state, i.e. on the transition into `S_FETCH` from `S_DECODE`, `S_LOAD`, `S_STORE`, `S_ALU` or `S_BRANCH`, and on entry to `S_HALT`.
  - The counter saturates at 16'hFFFF and is cleared by `rst`.
- Not defined: `instr_count` is tied to 0 and no counter flops are built.

## Structure
- `k_and_s_pkg` holds:
  - `decoded_instruction_type` (already shared with `data_path`)
  - the `ALU_*` 2-bit constants
  - the `cu_state_t` enum
- Sub-module `cu_branch_cond`: combinational; inputs are the instruction and the four flags; output is `taken`. It is shared for reuse by future pipelined variants.

## Test plan
- Reset release, instruction `I_NOP` → `S_IDLE` for 1 cycle, then `ir_enable`=1 in cycle 1, `pc_enable`=1 in cycle 2, `ir_enable` again in cycle 3.
- `I_ADD` → cycle 3 shows `write_reg_enable`=1, `flags_reg_enable`=1, `operation`=00, `c_sel`=0. `I_MOVE` shows `operation`=11 with `flags_reg_enable`=0.
- `I_STORE` then `I_LOAD` → `addr_sel`=1 with `ram_write_enable`=1 in STORE's cycle 3; `c_sel`=1 with `write_reg_enable`=1 in LOAD's cycle 3.
- `I_BZERO` with `zero_op`=1 → `branch`=1, `pc_enable`=1 in cycle 3. With `zero_op`=0 → both 0. Repeat for `I_BNEG` and `I_BNOV`.
- `I_HALT` → `halt`=1 from cycle 3, held for 20 cycles with all strobes 0. Asserting `rst` returns all outputs to 0 asynchronously.
- `rst` asserted during `S_STORE` → `ram_write_enable` falls before the next clock edge. With `CU_INSTR_COUNT_EN`, `instr_count` reads 0 after reset and 5 after five NOPs.
